fpu_issue_arbiter: RTL
======================

# fpu_issue_arbiter

Shares one `riscv_fpu` instance between `NUM_REQ` requesters, typically the scalar core's FP pipe and the AI accelerator's scalar-assist unit. It runs round-robin arbitration, registers the winner's operands, and drives the FPU's single-cycle `fpu_enable` pulse. It then waits for `fpu_ready` and returns the result to the winner through a valid/ready response. It also keeps per-requester sticky `fflags` accumulators and enforces a completion timeout.

## Interface
Parameters:
- `XLEN`, 64, operand/result width.
- `NUM_REQ`, 2, number of requesters (2..8).
- `TIMEOUT_CYCLES`, 64, maximum WAIT cycles before an error response (>= 2).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: request accepted (combinational, one-hot or zero).
- `req_op` in NUM_REQ*3: FPU op field, requester i at bits [3i+:3].
- `req_funct3` in NUM_REQ*3: funct3, same slicing.
- `req_funct7` in NUM_REQ*7: funct7, same slicing.
- `req_is_double` in NUM_REQ: double-precision select.
- `req_rs1`, `req_rs2`, `req_rs3` in NUM_REQ*XLEN each: operands (NaN-boxed for single precision).
- `rsp_valid` out NUM_REQ: response valid, one-hot.
- `rsp_ready` in NUM_REQ: response accepted.
- `rsp_result` out XLEN: result for the requester whose `rsp_valid` is high.
- `rsp_flags` out 5: {NV,DZ,OF,UF,NX} for that result.
- `rsp_error` out 1: timeout occurred.
- `fflags_acc` out NUM_REQ*5: sticky accumulated flags per requester.
- `fflags_clr` in NUM_REQ: clear that requester's accumulator.
- `fpu_enable` out 1: one-cycle issue strobe to the FPU.
- `fpu_op` out 3, `fpu_funct3` out 3, `fpu_funct7` out 7, `fpu_is_double` out 1: registered FPU controls.
- `fpu_rs1`, `fpu_rs2`, `fpu_rs3` out XLEN each: registered FPU operands.
- `fpu_result` in XLEN, `fpu_ready` in 1, `fpu_flags` in 5: FPU outputs.
- `busy` out 1: state != IDLE.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:** the round-robin winner among `req_valid` (search starts at `rr_ptr`) gets `req_ready`=1 combinationally. On handshake:
  - capture its op, funct3, funct7, is_double and operands into the `fpu_*` registers;
  - store `grant_idx`;
  - go to ISSUE.
  - No `req_valid` high: stay in IDLE, `req_ready`=0.
- **ISSUE:** `fpu_enable`=1 for exactly this cycle; then go to WAIT and clear the timeout counter.
- **WAIT:** sample `fpu_ready` every cycle.
  - When it is high, capture `fpu_result`/`fpu_flags` into the response registers with `rsp_error`=0, then go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 without `fpu_ready`, set result=0, flags=0, `rsp_error`=1, then go to RESP.
- **RESP:** `rsp_valid[grant_idx]`=1, held with stable data until `rsp_ready[grant_idx]`. On handshake:
  - `rr_ptr` = (`grant_idx`+1) mod NUM_REQ;
  - OR `rsp_flags` into `fflags_acc[grant_idx]` (error responses contribute 0);
  - go to IDLE.
- The `fpu_*` control/operand outputs hold their values from capture until the next accept. Only `fpu_enable` pulses.
- Accumulator rule: `fflags_clr[i]` in the same cycle as an OR into i gives acc = new flags (clear applies first). A clear on another index is independent.
- Requesters never see `req_ready` outside IDLE, so one operation is in flight at a time.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state IDLE, accumulators 0. Reset mid-operation drops the in-flight op with no response.
- Minimum latency (combinational FPU, `fpu_ready` high on the cycle after ISSUE):
  - accept in cycle 0;
  - `fpu_enable` in cycle 1;
  - capture in cycle 2;
  - `rsp_valid` from cycle 3.
- Back-to-back: after the RESP handshake in cycle N, the next accept can occur in cycle N+1. Throughput is 1 op per 4 cycles minimum.
- `fpu_ready` high during ISSUE is ignored; only WAIT samples it.
- Timeout: `rsp_valid` rises `TIMEOUT_CYCLES`+1 cycles after ISSUE.

## Structure
- Package `fpu_arb_pkg`:
  - `arb_state_e` enum {IDLE, ISSUE, WAIT, RESP};
  - `fflag_t` packed struct {nv,dz,of,uf,nx};
  - localparam `FFLAG_W`=5.
- Sub-module `rr_arbiter #(N)`:
  - inputs `req[N]`, `ptr`, `en`;
  - output one-hot `gnt[N]`, combinational.
  - Pointer update stays in the parent.

## Test plan
- **Single request:** requester 0 issues FADD.S 0xFFFFFFFF3FC00000 + 0xFFFFFFFF40200000 against a model FPU with ready the cycle after enable. Expect `fpu_enable` exactly one cycle (cycle 1), `rsp_valid[0]` at cycle 3, result 0xFFFFFFFF40800000, `rsp_error`=0.
- **Round-robin:** both requesters hold `req_valid` continuously for 4 ops. Grants go 0,1,0,1, and each `rsp_valid` is one-hot to the granted index.
- **Response backpressure:** hold `rsp_ready[1]`=0 for 5 cycles. `rsp_valid[1]`, result and flags stay stable, and no new `req_ready` appears until the handshake.
- **Timeout:** with `TIMEOUT_CYCLES`=8, the FPU never raises ready. Expect `rsp_error`=1, result 0, `fflags_acc` unchanged, and `rsp_valid` at ISSUE+9.
- **Sticky flags:** two ops return flags 0x01 then 0x10, giving `fflags_acc[0]`=0x11. Assert `fflags_clr[0]` in the same cycle as a third response with flags 0x04, giving `fflags_acc[0]`=0x04.
- **Reset mid-operation:** drop `rst_n` during WAIT. All outputs go to 0 asynchronously, no `rsp_valid` appears after release, and the first request after release is granted to requester 0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared types for the FPU issue arbiter.
// Holds FSM state encoding and the IEEE exception flag bundle.
package fpu_arb_pkg;

   localparam int FFLAG_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflag_t;

endpackage

// File: rtl/fpu_issue_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
// Search starts at ptr; lowest rotated offset wins.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 en,
   output logic [N-1:0]         gnt
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] sel;

   // Walk offsets from far to near so the nearest request overwrites.
   always_comb begin
      gnt = '0;
      sel = '0;
      if (en) begin
         for (int k = N - 1; k >= 0; k--) begin
            sel = PW'((int'(ptr) + k) % N);
            if (req[sel]) begin
               gnt      = '0;
               gnt[sel] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: shares one FPU between NUM_REQ requesters.
// One op in flight; round-robin grant, timeout, sticky flags.
module fpu_issue_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*3-1:0]       req_op,
   input  logic [NUM_REQ*3-1:0]       req_funct3,
   input  logic [NUM_REQ*7-1:0]       req_funct7,
   input  logic [NUM_REQ-1:0]         req_is_double,
   input  logic [NUM_REQ*XLEN-1:0]    req_rs1,
   input  logic [NUM_REQ*XLEN-1:0]    req_rs2,
   input  logic [NUM_REQ*XLEN-1:0]    req_rs3,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [XLEN-1:0]            rsp_result,
   output logic [FFLAG_W-1:0]         rsp_flags,
   output logic                       rsp_error,
   output logic [NUM_REQ*FFLAG_W-1:0] fflags_acc,
   input  logic [NUM_REQ-1:0]         fflags_clr,
   output logic                       fpu_enable,
   output logic [2:0]                 fpu_op,
   output logic [2:0]                 fpu_funct3,
   output logic [6:0]                 fpu_funct7,
   output logic                       fpu_is_double,
   output logic [XLEN-1:0]            fpu_rs1,
   output logic [XLEN-1:0]            fpu_rs2,
   output logic [XLEN-1:0]            fpu_rs3,
   input  logic [XLEN-1:0]            fpu_result,
   input  logic                       fpu_ready,
   input  logic [FFLAG_W-1:0]         fpu_flags,
   output logic                       busy
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   arb_state_e               state_q;
   logic [IW-1:0]            grant_q;
   logic [IW-1:0]            rr_ptr_q;
   logic [CW-1:0]            cnt_q;
   logic                     fpu_enable_q;
   logic [2:0]               fpu_op_q;
   logic [2:0]               fpu_funct3_q;
   logic [6:0]               fpu_funct7_q;
   logic                     fpu_is_double_q;
   logic [XLEN-1:0]          fpu_rs1_q;
   logic [XLEN-1:0]          fpu_rs2_q;
   logic [XLEN-1:0]          fpu_rs3_q;
   logic [NUM_REQ-1:0]       rsp_valid_q;
   logic [XLEN-1:0]          rsp_result_q;
   fflag_t                   rsp_flags_q;
   logic                     rsp_error_q;
   logic [NUM_REQ-1:0][FFLAG_W-1:0] acc_q;

   logic [NUM_REQ-1:0]       gnt;
   logic [IW-1:0]            gidx;
   logic                     rsp_hs;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_rr (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .en  (state_q == IDLE),
      .gnt (gnt)
   );

   // Encode the one-hot grant into an index for operand muxing.
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gidx = IW'(i);
      end
   end

   assign req_ready = gnt;
   assign rsp_hs    = (state_q == RESP) && rsp_ready[grant_q];

   // Issue FSM: accept, strobe the FPU, wait or time out, respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         grant_q         <= '0;
         rr_ptr_q        <= '0;
         cnt_q           <= '0;
         fpu_enable_q    <= 1'b0;
         fpu_op_q        <= '0;
         fpu_funct3_q    <= '0;
         fpu_funct7_q    <= '0;
         fpu_is_double_q <= 1'b0;
         fpu_rs1_q       <= '0;
         fpu_rs2_q       <= '0;
         fpu_rs3_q       <= '0;
         rsp_valid_q     <= '0;
         rsp_result_q    <= '0;
         rsp_flags_q     <= '0;
         rsp_error_q     <= 1'b0;
      end else begin
         fpu_enable_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (|gnt) begin
                  fpu_op_q        <= req_op[gidx*3 +: 3];
                  fpu_funct3_q    <= req_funct3[gidx*3 +: 3];
                  fpu_funct7_q    <= req_funct7[gidx*7 +: 7];
                  fpu_is_double_q <= req_is_double[gidx];
                  fpu_rs1_q       <= req_rs1[gidx*XLEN +: XLEN];
                  fpu_rs2_q       <= req_rs2[gidx*XLEN +: XLEN];
                  fpu_rs3_q       <= req_rs3[gidx*XLEN +: XLEN];
                  grant_q         <= gidx;
                  fpu_enable_q    <= 1'b1;
                  state_q         <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (fpu_ready) begin
                  rsp_result_q <= fpu_result;
                  rsp_flags_q  <= fpu_flags;
                  rsp_error_q  <= 1'b0;
                  rsp_valid_q  <= NUM_REQ'(1) << grant_q;
                  state_q      <= RESP;
               end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_result_q <= '0;
                  rsp_flags_q  <= '0;
                  rsp_error_q  <= 1'b1;
                  rsp_valid_q  <= NUM_REQ'(1) << grant_q;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_hs) begin
                  rsp_valid_q <= '0;
                  rr_ptr_q    <= (grant_q == IW'(NUM_REQ - 1)) ?
                                 '0 : grant_q + 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Sticky flags: a same-cycle clear is applied before the OR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_hs && grant_q == IW'(i)) begin
               acc_q[i] <= (fflags_clr[i] ? '0 : acc_q[i]) | rsp_flags_q;
            end else if (fflags_clr[i]) begin
               acc_q[i] <= '0;
            end
         end
      end
   end

   assign fpu_enable    = fpu_enable_q;
   assign fpu_op        = fpu_op_q;
   assign fpu_funct3    = fpu_funct3_q;
   assign fpu_funct7    = fpu_funct7_q;
   assign fpu_is_double = fpu_is_double_q;
   assign fpu_rs1       = fpu_rs1_q;
   assign fpu_rs2       = fpu_rs2_q;
   assign fpu_rs3       = fpu_rs3_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_flags     = rsp_flags_q;
   assign rsp_error     = rsp_error_q;
   assign fflags_acc    = acc_q;
   assign busy          = (state_q != IDLE);

endmodule
